mem_arbiter: RTL and testbench

- Shares one single-port RAM between the instruction-fetch port (iREN) and the data port (dREN/dWEN) that the control unit generates.
- Each port is served with a request/hit handshake. Data has priority, with a starvation guard for fetch.
- A timeout aborts a RAM access that never completes.
- Sits between the datapath (fetch stage and memory stage) and the RAM model/cache.

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and RAM side of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter: data priority, fetch starvation guard, access timeout
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t            state, state_n;
  logic [SW-1:0]     starve_cnt;
  logic [7:0]        tmo_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_wr;

  logic grant_d, grant_i, done, expire, active;
  logic ihit, dhit, ram_ren, ram_wen;
  logic [DATA_W-1:0] iload, dload, ramstore;
  logic [ADDR_W-1:0] ramaddr;

  always_comb begin
    state_n  = state;
    active   = (state != IDLE);
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    done     = active && bus.ram_ready;
    expire   = active && !bus.ram_ready && (tmo_cnt == 8'(TIMEOUT));
    ihit     = 1'b0;
    dhit     = 1'b0;
    ram_ren  = 1'b0;
    ram_wen  = 1'b0;
    iload    = '0;
    dload    = '0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        grant_d = (bus.dREN || bus.dWEN) && (!bus.iREN || (starve_cnt < SW'(STARVE_MAX)));
        grant_i = !grant_d && bus.iREN;
        if (grant_d)      state_n = DACC;
        else if (grant_i) state_n = IACC;
      end
      IACC: begin
        ram_ren  = 1'b1;
        ramaddr  = addr_q;
        ramstore = data_q;
        ihit     = bus.ram_ready;
        iload    = bus.ram_ready ? bus.ramload : '0;
        if (done || expire) state_n = IDLE;
      end
      DACC: begin
        ram_ren  = !op_wr;
        ram_wen  = op_wr;
        ramaddr  = addr_q;
        ramstore = data_q;
        dhit     = bus.ram_ready;
        dload    = (bus.ram_ready && !op_wr) ? bus.ramload : '0;
        if (done || expire) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_wr      <= 1'b0;
    end else begin
      state <= state_n;
      if (grant_d) begin
        addr_q <= bus.daddr;
        data_q <= bus.dstore;
        op_wr  <= bus.dWEN;
      end else if (grant_i) begin
        addr_q <= bus.iaddr;
      end
      // Only data grants taken over a waiting fetch count toward starvation
      if (grant_d && bus.iREN) begin
        if (starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else if (state == IDLE && (grant_i || !bus.iREN)) begin
        starve_cnt <= '0;
      end
      if (active && !bus.ram_ready && !expire) tmo_cnt <= tmo_cnt + 8'd1;
      else                                     tmo_cnt <= 8'd0;
    end
  end

  assign bus.ihit     = ihit;
  assign bus.iload    = iload;
  assign bus.dhit     = dhit;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ramaddr;
  assign bus.ramstore = ramstore;
  assign bus.busy     = active;
  assign bus.err      = expire;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 255;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: one outstanding access at a time, described by what is being served
  bit          m_busy = 0, m_data = 0, m_wr = 0;
  logic [31:0] m_addr = '0, m_store = '0;
  int          m_wait = 0, m_streak = 0;

  int  cnt_ihit = 0, cnt_dhit = 0, cnt_err = 0;
  byte evlog[$];
  bit  d_repeat = 0;
  logic [31:0] o_iload, o_dload;
  logic        o_ren, o_wen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        e_ihit, e_dhit, e_ren, e_wen, e_busy, e_err;
    logic [31:0] e_iload, e_dload, e_raddr, e_rstore;
    bit          dreq;
    @(negedge CLK);
    {e_ihit, e_dhit, e_ren, e_wen, e_busy, e_err} = '0;
    e_iload = '0; e_dload = '0; e_raddr = '0; e_rstore = '0;
    if (RST) begin
      m_busy = 0; m_streak = 0; m_addr = '0; m_store = '0; m_wait = 0;
    end else if (!m_busy) begin
      dreq = bus.dREN || bus.dWEN;
      if (dreq && (!bus.iREN || m_streak < STARVE_MAX)) begin
        m_busy = 1; m_data = 1; m_wr = bus.dWEN; m_addr = bus.daddr; m_store = bus.dstore; m_wait = 0;
        m_streak = bus.iREN ? ((m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX) : 0;
      end else if (bus.iREN) begin
        m_busy = 1; m_data = 0; m_addr = bus.iaddr; m_wait = 0; m_streak = 0;
      end else begin
        m_streak = 0;
      end
    end else begin
      e_busy = 1; e_ren = !(m_data && m_wr); e_wen = m_data && m_wr;
      e_raddr = m_addr; e_rstore = m_store;
      if (bus.ram_ready) begin
        if (m_data) begin e_dhit = 1; e_dload = m_wr ? 32'd0 : bus.ramload; end
        else        begin e_ihit = 1; e_iload = bus.ramload; end
        m_busy = 0;
      end else if (m_wait == TIMEOUT) begin
        e_err = 1; m_busy = 0;
      end else begin
        m_wait++;
      end
    end
    check("ihit", bus.ihit, e_ihit);
    check("iload", bus.iload, e_iload);
    check("dhit", bus.dhit, e_dhit);
    check("dload", bus.dload, e_dload);
    check("ramREN", bus.ramREN, e_ren);
    check("ramWEN", bus.ramWEN, e_wen);
    check("ramaddr", bus.ramaddr, e_raddr);
    check("ramstore", bus.ramstore, e_rstore);
    check("busy", bus.busy, e_busy);
    check("err", bus.err, e_err);
    o_iload = bus.iload; o_dload = bus.dload; o_ren = bus.ramREN; o_wen = bus.ramWEN;
    if (bus.ihit) begin cnt_ihit++; evlog.push_back("I"); end
    if (bus.dhit) begin cnt_dhit++; evlog.push_back("D"); end
    if (bus.err)  begin cnt_err++;  evlog.push_back("E"); end
    @(posedge CLK);
    #1;
    if (e_ihit) bus.iREN = 0;
    if (e_dhit) begin
      if (d_repeat) begin bus.daddr = bus.daddr + 32'd4; bus.dstore = $urandom; end
      else begin bus.dREN = 0; bus.dWEN = 0; end
    end
    if (e_err) begin bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; end
  endtask

  initial begin
    int k, n0, lead, err_at;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0; bus.daddr = '0;
    bus.dstore = '0; bus.ramload = '0; bus.ram_ready = 0;
    step(); step();
    #1 RST = 0;
    step();

    // Single fetch with ram_ready arriving on the third IACC cycle
    bus.iREN = 1; bus.iaddr = 32'h10; bus.ramload = 32'h3C01_0001;
    n0 = cnt_ihit;
    step(); step(); step();
    bus.ram_ready = 1;
    step();
    check("fetch_iload", o_iload, 32'h3C01_0001);
    bus.ram_ready = 0;
    step();
    check("fetch_hits", cnt_ihit - n0, 1);

    // Simultaneous fetch and write: data first
    evlog.delete();
    bus.iREN = 1; bus.iaddr = 32'h14; bus.dWEN = 1; bus.daddr = 32'h100;
    bus.dstore = 32'hDEAD_BEEF; bus.ram_ready = 1;
    for (k = 0; k < 12 && evlog.size() < 2; k++) step();
    check("simul_count", evlog.size(), 2);
    if (evlog.size() >= 2) begin
      check("simul_first", evlog[0], "D");
      check("simul_second", evlog[1], "I");
    end
    step();

    // Starvation guard
    evlog.delete();
    bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.daddr = 32'h300; d_repeat = 1;
    for (k = 0; k < 40 && evlog.size() < 6; k++) step();
    d_repeat = 0; bus.dREN = 0; bus.iREN = 0;
    check("starve_count", evlog.size(), 6);
    lead = 0;
    while (lead < evlog.size() && evlog[lead] == "D") lead++;
    check("starve_lead_d", lead, STARVE_MAX);
    if (evlog.size() >= 6) begin
      check("starve_then_i", evlog[4], "I");
      check("starve_then_d", evlog[5], "D");
    end
    step(); step();

    // Timeout with ram_ready never asserted
    bus.ram_ready = 0; bus.dREN = 1; bus.daddr = 32'h20;
    n0 = cnt_dhit; err_at = -1;
    step();
    for (k = 1; k <= 300 && err_at < 0; k++) begin
      step();
      if (cnt_err > 0) err_at = k;
    end
    check("tmo_cycle", err_at, 256);
    check("tmo_nohit", cnt_dhit - n0, 0);
    step();

    // ram_ready on the timeout cycle completes instead
    bus.dREN = 1; bus.daddr = 32'h24; n0 = cnt_err;
    step();
    for (k = 0; k < 255; k++) step();
    bus.ram_ready = 1; bus.ramload = 32'h5555_AAAA;
    k = cnt_dhit;
    step();
    check("tmo_edge_hit", cnt_dhit - k, 1);
    check("tmo_edge_noerr", cnt_err - n0, 0);
    bus.ram_ready = 0;
    step();

    // dREN and dWEN together: write wins
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h8; bus.dstore = 32'h0BAD_F00D;
    bus.ram_ready = 1; bus.ramload = 32'h1234_5678;
    step(); step();
    check("both_wen", o_wen, 1'b1);
    check("both_ren", o_ren, 1'b0);
    check("both_dload", o_dload, 32'd0);
    bus.ram_ready = 0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!bus.iREN && ($urandom % 4) == 0) begin
        bus.iREN = 1; bus.iaddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(bus.dREN || bus.dWEN) && ($urandom % 4) == 0) begin
        bus.dREN = 1'($urandom); bus.dWEN = 1'($urandom);
        if (!bus.dREN && !bus.dWEN) bus.dREN = 1;
        bus.daddr = $urandom & 32'hFFFF_FFFC; bus.dstore = $urandom;
      end
      bus.ram_ready = (($urandom % 10) < 7);
      bus.ramload = $urandom;
      step();
    end
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ready = 0;
    for (k = 0; k < 300 && m_busy; k++) step();
    step();

    // Reset in the middle of a write
    bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'h7777_0000;
    step(); step();
    check("pre_rst_wen", o_wen, 1'b1);
    RST = 1;
    #1;
    check("rst_ramWEN", bus.ramWEN, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_dhit", bus.dhit, 1'b0);
    bus.dWEN = 0; bus.ram_ready = 1;
    step();
    RST = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
